muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: wide, default 32, the operand width and the width of each of the hi and lo registers.
REQ-002 SHALL have port: clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to launch an operation, sampled at a clk edge.
REQ-005 SHALL have port: op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port: a  input  wide  multiplicand or dividend (rs).
REQ-007 SHALL have port: b  input  wide  multiplier or divisor (rt).
REQ-008 SHALL have port: we_hi  input  1  direct write of a into hi (MTHI).
REQ-009 SHALL have port: we_lo  input  1  direct write of a into lo (MTLO).
REQ-010 SHALL have port: busy  output  1  operation in progress; the core stalls MFHI/MFLO while this is high.
REQ-011 SHALL have port: done  output  1  one-cycle pulse marking that hi/lo hold a new result.
REQ-012 SHALL have port: hi  output  wide  HI register (product upper half, or remainder).
REQ-013 SHALL have port: lo  output  wide  LO register (product lower half, or quotient).

Function
REQ-014 SHALL implement states IDLE, CALC and FIX, with a 5-bit iteration counter (log2 wide bits).
REQ-015 SHALL, in IDLE, accept start at a clk edge, latch op and the operand magnitudes, clear the counter, and enter CALC.
REQ-016 SHALL perform one iteration per cycle in CALC: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 SHALL leave CALC for FIX at the edge where the counter equals wide-1, giving exactly wide iterations.
REQ-018 SHALL, in FIX, apply sign correction, write hi and lo, and return to IDLE at the same edge.
REQ-019 SHALL assert busy from the edge that accepts start until the FIX edge, i.e. for wide+1 cycles.
REQ-020 SHALL pulse done high for exactly the one cycle following the FIX edge.
REQ-021 SHALL make the result visible on hi/lo wide+1 edges after the start edge.
REQ-022 SHALL, for MULT, use operand magnitudes and negate the 2*wide product when the operand signs differ.
REQ-023 SHALL, for DIV, negate the quotient when the operand signs differ and give the remainder the sign of a.
REQ-024 SHALL, for DIVU by zero, produce lo = all ones and hi = a, with the normal latency.
REQ-025 SHALL, for DIV by zero, produce lo = all ones and hi = a, with no sign correction applied.
REQ-026 SHALL, for DIV of the most negative value by -1, produce lo = 0x80000000 and hi = 0, with no trap.
REQ-027 SHALL ignore start while busy is high, with no restart and no corruption of the operation in progress.
REQ-028 SHALL apply we_hi/we_lo only in IDLE; they take effect at the next edge, and both may be high in the same cycle.
REQ-029 SHALL ignore we_hi/we_lo while busy is high.
REQ-030 SHALL, when start and we_hi/we_lo are high in the same IDLE cycle, give start priority and drop the write.
REQ-031 SHALL keep hi and lo unchanged during CALC; they update only at FIX or by a direct write.

Reset
REQ-032 SHALL, while rst is low, force the state to IDLE, the counter to 0, busy and done to 0, and hi and lo to 0, independent of clk.
REQ-033 SHALL, on reset mid-operation, abort the operation, produce no done pulse, and accept a new start on the first edge after rst rises.

Verification
REQ-034 SHALL cover: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done high for 1 cycle.
REQ-035 SHALL cover: MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-036 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
REQ-037 SHALL cover: second start issued at cycle 10 of a busy MULTU -> ignored, first result intact, only one done pulse.
REQ-038 SHALL cover: rst driven low at cycle 15 of a DIV -> hi=lo=0, busy=0, no done; a following DIVU a=9, b=4 -> lo=2, hi=1.
REQ-039 SHALL cover: we_hi and we_lo high in IDLE with a=0x1234 -> hi=lo=0x1234; the same writes issued during busy -> ignored.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply/divide unit holding the HI/LO pair.
//   One iteration per clock. Shift-add is used for MULTU/MULT and restoring
//   shift-subtract for DIVU/DIV. The operand signs are removed at launch and
//   put back in a single FIX cycle.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      launch request, accepted only when idle
//   op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b       rs / rt operands (a is also the MTHI/MTLO data)
//   we_hi/lo   direct write of a into hi/lo, accepted only when idle
//   busy       operation in flight (wide+1 cycles)
//   done       one-cycle pulse after hi/lo receive a result
//   hi, lo     HI/LO architectural registers
module muldiv_unit #(
    parameter int unsigned wide = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [wide-1:0] a,
    input  logic [wide-1:0] b,
    input  logic            we_hi,
    input  logic            we_lo,
    output logic            busy,
    output logic            done,
    output logic [wide-1:0] hi,
    output logic [wide-1:0] lo
);

    localparam int unsigned W     = wide;
    localparam int unsigned P_W   = 2 * wide;
    localparam int unsigned CNT_W = (wide > 1) ? $clog2(wide) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(wide - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [W-1:0]     acc_hi_q, acc_hi_d;
    logic [W-1:0]     acc_lo_q, acc_lo_d;

    // Operand magnitudes; only signed ops (op[0]) strip the sign.
    logic         a_neg_in, b_neg_in;
    logic [W-1:0] a_mag, b_mag;

    assign a_neg_in = op[0] & a[W-1];
    assign b_neg_in = op[0] & b[W-1];
    assign a_mag    = a_neg_in ? (~a + W'(1)) : a;
    assign b_mag    = b_neg_in ? (~b + W'(1)) : b;

    // Multiply step: conditional add of the multiplicand into the upper half.
    logic [W:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + {1'b0, opnd_q};

    // Divide step: shift remainder:quotient left, subtract if it fits.
    // The subtraction is exact in W bits because the shifted remainder is
    // always below twice the divisor.
    logic [W:0]   div_sh;
    logic         div_ge;
    logic [W-1:0] div_sub;
    assign div_sh  = {acc_hi_q, acc_lo_q[W-1]};
    assign div_ge  = (div_sh >= {1'b0, opnd_q});
    assign div_sub = div_sh[W-1:0] - opnd_q;

    // Sign correction applied in FIX. A zero divisor leaves the quotient
    // as all ones, and the remainder path then reproduces a exactly.
    logic           neg_res;
    logic           div_zero;
    logic [P_W-1:0] prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;

    assign neg_res  = neg_a_q ^ neg_b_q;
    assign div_zero = (opnd_q == '0);
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_res ? (~prod + P_W'(1)) : prod;
    assign quo_fix  = div_zero ? '1 : (neg_res ? (~acc_lo_q + W'(1)) : acc_lo_q);
    assign rem_fix  = neg_a_q ? (~acc_hi_q + W'(1)) : acc_hi_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // start wins over a same-cycle direct write
                    state_d  = CALC;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_a_d  = a_neg_in;
                    neg_b_d  = b_neg_in;
                    opnd_d   = b_mag;
                    acc_hi_d = '0;
                    acc_lo_d = a_mag;
                end else begin
                    if (we_hi) begin
                        hi_d = a;
                    end
                    if (we_lo) begin
                        lo_d = a;
                    end
                end
            end

            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!is_div_q) begin
                    if (acc_lo_q[0]) begin
                        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[W-1:1]};
                    end else begin
                        {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[W-1:1]};
                    end
                end else begin
                    acc_hi_d = div_ge ? div_sub : div_sh[W-1:0];
                    acc_lo_d = {acc_lo_q[W-2:0], div_ge};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end

            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[P_W-1:W];
                    lo_d = prod_fix[W-1:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed corner cases plus randomized operations for
// muldiv_unit, checked against a plain-arithmetic HI/LO reference.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         we_hi;
    logic         we_lo;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.wide(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} from ordinary integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy;
        logic [63:0]     res;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        case (o)
            2'b00: res = ux * uy;
            2'b01: res = sx * sy;
            2'b10: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    sq = longint'(ux / uy);
                    sr = longint'(ux % uy);
                    res = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    res = {sr[31:0], sq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Launch one operation and follow it for 40 cycles.
    // poke_kind 1: extra start at cycle poke_k; 2: we_hi/we_lo at cycle poke_k.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int poke_k, input int poke_kind,
                          input bit launch_we, input bit rel_rst);
        logic [63:0]  exp;
        logic [W-1:0] hi_pre, lo_pre, hi0, lo0, rhi, rlo;
        int           nbusy, ndone, done_k;
        bit           held;
        exp = model(o, av, bv);
        nbusy = 0; ndone = 0; done_k = -1; held = 1'b1; rhi = '0; rlo = '0;
        @(negedge clk);
        if (rel_rst) rst = 1'b1;
        hi_pre = hi; lo_pre = lo;
        op = o; a = av; b = bv; start = 1'b1;
        we_hi = launch_we; we_lo = launch_we;
        @(posedge clk);
        #1;
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        hi0 = hi; lo0 = lo;
        check({tag, "/accept_hilo"}, {hi0, lo0}, {hi_pre, lo_pre});
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
            if (k == poke_k) begin
                if (poke_kind == 1) begin
                    start = 1'b1; op = 2'b11; a = 32'h0000_0007; b = 32'h0000_0003;
                end else if (poke_kind == 2) begin
                    we_hi = 1'b1; we_lo = 1'b1; a = 32'hDEAD_BEEF;
                end
            end
            if (busy) begin
                nbusy++;
                if (hi !== hi0 || lo !== lo0) held = 1'b0;
            end
            if (done) begin
                ndone++;
                if (done_k < 0) begin
                    done_k = k; rhi = hi; rlo = lo;
                end
            end
        end
        check({tag, "/busy_cycles"}, 64'(nbusy), 64'(W + 1));
        check({tag, "/done_cycle"}, 64'(done_k), 64'(W + 2));
        check({tag, "/done_count"}, 64'(ndone), 64'd1);
        check({tag, "/hilo_held"}, 64'(held), 64'd1);
        check({tag, "/result"}, {rhi, rlo}, exp);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  ndone_rst;
        bit  quiet;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; we_hi = 1'b0; we_lo = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("reset/hi", 64'(hi), 64'd0);
        check("reset/lo", 64'(lo), 64'd0);
        check("reset/busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
        check("multu_max/const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // Reset in the middle of a DIV, then a DIVU on the first edge after release.
        @(negedge clk);
        op = 2'b11; a = 32'hFFFF_FF9C; b = 32'h0000_0007; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort/hilo", {hi, lo}, 64'd0);
        check("abort/busy_done", {62'd0, busy, done}, 64'd0);
        ndone_rst = 0; quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) quiet = 1'b0;
            if (done) ndone_rst++;
        end
        check("abort/quiet", 64'(quiet), 64'd1);
        run_op("abort/divu_9_4", 2'b10, 32'd9, 32'd4, 0, 0, 1'b0, 1'b1);
        check("abort/divu_const", {hi, lo}, {32'd1, 32'd2});
        check("abort/no_done", 64'(ndone_rst), 64'd0);

        run_op("mult_m3_7", 2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0, 1'b0, 1'b0);
        check("mult_m3_7/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, 1'b0);
        check("div_m7_2/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_by0", 2'b10, 32'd100, 32'd0, 0, 0, 1'b0, 1'b0);
        check("divu_by0/const", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
        run_op("div_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 0, 0, 1'b0, 1'b0);
        check("div_by0/const", {hi, lo}, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
        check("div_min_m1/const", {hi, lo}, {32'h0, 32'h8000_0000});

        run_op("restart_ignored", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1, 1'b0, 1'b0);

        // Direct writes in IDLE.
        @(negedge clk);
        a = 32'h0000_1234; we_hi = 1'b1; we_lo = 1'b1;
        @(posedge clk);
        #1 we_hi = 1'b0; we_lo = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'h1234, 32'h1234});
        @(negedge clk);
        a = 32'hCAFE_0000; we_hi = 1'b1;
        @(posedge clk);
        #1 we_hi = 1'b0;
        check("mthi_only", {hi, lo}, {32'hCAFE_0000, 32'h1234});

        run_op("start_beats_we", 2'b00, 32'd5, 32'd6, 0, 0, 1'b1, 1'b0);
        run_op("we_during_busy", 2'b11, 32'hFFFF_FF00, 32'd9, 5, 2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 0, 0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
